// File: rtl/sir_chk_pkg.sv
// sir_chk_pkg: shared state encoding and fail codes for the sir_cpu retire checker
package sir_chk_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;
  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_DATA    = 2'd1;
  localparam logic [1:0] FC_INVALID = 2'd2;
  localparam logic [1:0] FC_TIMEOUT = 2'd3;
endpackage

// File: rtl/sir_chk_exp_table.sv
// sir_chk_exp_table: DEPTH x (rd, data) expected table, one write port, async read
// clk          write clock
// we/waddr     write strobe and slot
// wrd/wdata    expected destination register and value to store
// raddr        read slot; rd/data return that slot combinationally
// Contents are deliberately not reset.
module sir_chk_exp_table #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [4:0]       wrd,
  input  logic [XLEN-1:0]  wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  data
);
  logic [4:0]      mem_rd   [DEPTH];
  logic [XLEN-1:0] mem_data [DEPTH];
  always_ff @(posedge clk)
    if (we) begin
      mem_rd[waddr]   <= wrd;
      mem_data[waddr] <= wdata;
    end
  assign rd   = mem_rd[raddr];
  assign data = mem_data[raddr];
endmodule

// File: rtl/sir_retire_checker.sv
// sir_retire_checker: in-order writeback checker against a loaded expected table
// Inputs : clk, rst (async, active-high), start pulse, exp_we/exp_addr/exp_rd/exp_data
//          table load, exp_count (sampled on start), wb_valid/wb_rd/wb_data writeback
//          stream, cpu_invalid flag.
// Outputs: busy, done, pass, fail, timeout, fail_code, fail_idx, match_count,
//          cycle_count, fail_rd, fail_data.
// Define SIR_CHK_CAPTURE_EN to capture the offending writeback into fail_rd/fail_data;
// otherwise those outputs are tied to 0.
module sir_retire_checker
  import sir_chk_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 100,
  parameter int CYC_W          = 32,
  localparam int IDX_W         = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             exp_we,
  input  logic [IDX_W-1:0] exp_addr,
  input  logic [4:0]       exp_rd,
  input  logic [XLEN-1:0]  exp_data,
  input  logic [IDX_W:0]   exp_count,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             cpu_invalid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [1:0]       fail_code,
  output logic [IDX_W-1:0] fail_idx,
  output logic [IDX_W:0]   match_count,
  output logic [CYC_W-1:0] cycle_count,
  output logic [4:0]       fail_rd,
  output logic [XLEN-1:0]  fail_data
);
  localparam logic [IDX_W:0]   DEPTH_C = (IDX_W+1)'(DEPTH);
  localparam logic [CYC_W-1:0] TO_LAST = CYC_W'(TIMEOUT_CYCLES - 1);
  state_t           state, state_n;
  logic [IDX_W:0]   count, count_n, match_count_n, start_count;
  logic [CYC_W-1:0] cycle_count_n;
  logic [1:0]       fail_code_n;
  logic [IDX_W-1:0] fail_idx_n;
  logic             timeout_n;
  logic [4:0]       cur_rd;
  logic [XLEN-1:0]  cur_data;
  logic             idle_like, hit, last, fail_entry;
  assign idle_like   = state != RUN;
  assign start_count = exp_count > DEPTH_C ? DEPTH_C : exp_count;
  sir_chk_exp_table #(.XLEN(XLEN), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_table (
    .clk   (clk),
    .we    (exp_we && idle_like),
    .waddr (exp_addr),
    .wrd   (exp_rd),
    .wdata (exp_data),
    .raddr (match_count[IDX_W-1:0]),
    .rd    (cur_rd),
    .data  (cur_data)
  );
  // rd==0 writes are architectural no-ops, so they never consume an entry
  assign hit  = wb_valid && wb_rd != 5'd0 && wb_rd == cur_rd;
  assign last = hit && wb_data == cur_data && match_count + 1'b1 == count;
  always_comb begin
    state_n       = state;
    count_n       = count;
    match_count_n = match_count;
    cycle_count_n = cycle_count;
    fail_code_n   = fail_code;
    fail_idx_n    = fail_idx;
    timeout_n     = timeout;
    if (idle_like && start) begin
      count_n       = start_count;
      match_count_n = '0;
      cycle_count_n = '0;
      fail_code_n   = FC_NONE;
      fail_idx_n    = '0;
      timeout_n     = 1'b0;
      state_n       = start_count == '0 ? PASS : RUN;
    end else if (state == RUN) begin
      cycle_count_n = cycle_count == '1 ? cycle_count : cycle_count + 1'b1;
      if (cpu_invalid) begin
        state_n     = FAIL;
        fail_code_n = FC_INVALID;
        fail_idx_n  = match_count[IDX_W-1:0];
      end else if (last) begin
        state_n       = PASS;
        match_count_n = match_count + 1'b1;
      end else if (hit && wb_data != cur_data) begin
        state_n     = FAIL;
        fail_code_n = FC_DATA;
        fail_idx_n  = match_count[IDX_W-1:0];
      end else begin
        match_count_n = hit ? match_count + 1'b1 : match_count;
        if (cycle_count == TO_LAST) begin
          state_n     = FAIL;
          fail_code_n = FC_TIMEOUT;
          fail_idx_n  = match_count[IDX_W-1:0];
          timeout_n   = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      match_count <= '0;
      cycle_count <= '0;
      fail_code   <= FC_NONE;
      fail_idx    <= '0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_n;
      count       <= count_n;
      match_count <= match_count_n;
      cycle_count <= cycle_count_n;
      fail_code   <= fail_code_n;
      fail_idx    <= fail_idx_n;
      timeout     <= timeout_n;
    end
  assign fail_entry = state == RUN && state_n == FAIL;
`ifdef SIR_CHK_CAPTURE_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fail_rd   <= '0;
      fail_data <= '0;
    end else if (idle_like && start) begin
      fail_rd   <= '0;
      fail_data <= '0;
    end else if (fail_entry) begin
      fail_rd   <= wb_valid ? wb_rd : '0;
      fail_data <= wb_valid ? wb_data : '0;
    end
`else
  assign fail_rd   = '0;
  assign fail_data = '0;
  logic unused_ok;
  assign unused_ok = fail_entry;
`endif
  assign busy = state == RUN;
  assign pass = state == PASS;
  assign fail = state == FAIL;
  assign done = pass || fail;
endmodule

// File: tb/tb_sir_retire_checker.sv
// tb_sir_retire_checker: directed self-checking bench for sir_retire_checker
module tb_sir_retire_checker;
  logic        clk = 0, rst = 1, start = 0, exp_we = 0;
  logic [3:0]  exp_addr = 0;
  logic [4:0]  exp_rd = 0;
  logic [63:0] exp_data = 0;
  logic [4:0]  exp_count = 0;
  logic        wb_valid = 0;
  logic [4:0]  wb_rd = 0;
  logic [63:0] wb_data = 0;
  logic        cpu_invalid = 0;
  logic        busy, done, pass, fail, timeout;
  logic [1:0]  fail_code;
  logic [3:0]  fail_idx;
  logic [4:0]  match_count;
  logic [31:0] cycle_count;
  logic [4:0]  fail_rd;
  logic [63:0] fail_data;
  int n_vec = 0, n_bad = 0;
  sir_retire_checker dut (
    .clk(clk), .rst(rst), .start(start), .exp_we(exp_we), .exp_addr(exp_addr),
    .exp_rd(exp_rd), .exp_data(exp_data), .exp_count(exp_count),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .cpu_invalid(cpu_invalid),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .fail_code(fail_code), .fail_idx(fail_idx), .match_count(match_count),
    .cycle_count(cycle_count), .fail_rd(fail_rd), .fail_data(fail_data)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d", tag, got, want);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [3:0] a, input logic [4:0] r, input logic [63:0] d);
    exp_we = 1; exp_addr = a; exp_rd = r; exp_data = d;
    tick();
    exp_we = 0;
  endtask
  task automatic go(input logic [4:0] n);
    exp_count = n; start = 1;
    tick();
    start = 0;
  endtask
  task automatic wb(input logic [4:0] r, input logic [63:0] d, input logic inv = 0);
    wb_valid = 1; wb_rd = r; wb_data = d; cpu_invalid = inv;
    tick();
    wb_valid = 0; cpu_invalid = 0;
  endtask
  initial begin
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail_code", fail_code, 0);
    chk("rst_cycle", cycle_count, 0);
    tick();
    rst = 0;
    load(0, 3, 1234);
    go(1);
    chk("single_busy", busy, 1);
    wb(1, 5);
    chk("single_early_pass", pass, 0);
    chk("single_early_mc", match_count, 0);
    wb(3, 1234);
    chk("single_pass", pass, 1);
    chk("single_mc", match_count, 1);
    chk("single_code", fail_code, 0);
    chk("single_busy_off", busy, 0);
    load(0, 1, 10);
    load(1, 2, 20);
    load(2, 3, 30);
    go(3);
    wb(2, 20);
    chk("seq_early_x2", match_count, 0);
    wb(1, 10);
    chk("seq_x1", match_count, 1);
    wb(5, 7);
    chk("seq_x5", match_count, 1);
    wb(2, 20);
    chk("seq_x2", match_count, 2);
    chk("seq_not_yet", pass, 0);
    wb(3, 30);
    chk("seq_pass", pass, 1);
    chk("seq_mc", match_count, 3);
    load(0, 3, 1234);
    go(1);
    wb(3, 1235);
    chk("data_fail", fail, 1);
    chk("data_code", fail_code, 1);
    chk("data_idx", fail_idx, 0);
`ifdef SIR_CHK_CAPTURE_EN
    chk("data_cap_rd", fail_rd, 3);
    chk("data_cap_data", fail_data, 1235);
`else
    chk("data_cap_rd_tied", fail_rd, 0);
    chk("data_cap_data_tied", fail_data, 0);
`endif
    wb(3, 1234);
    tick(2);
    chk("data_sticky", fail, 1);
    chk("data_sticky_pass", pass, 0);
    go(1);
    chk("to_cycle0", cycle_count, 0);
    tick(99);
    chk("to_cycle99", cycle_count, 99);
    chk("to_not_yet", fail, 0);
    tick();
    chk("to_fail", fail, 1);
    chk("to_timeout", timeout, 1);
    chk("to_code", fail_code, 3);
    chk("to_cycle100", cycle_count, 100);
    go(1);
    chk("to_cleared", timeout, 0);
    wb(3, 1234, 1);
    chk("prio_inv_fail", fail, 1);
    chk("prio_inv_code", fail_code, 2);
    go(1);
    tick(99);
    wb(3, 1234);
    chk("prio_to_pass", pass, 1);
    chk("prio_to_timeout", timeout, 0);
    go(1);
    tick(2);
    rst = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_cycle", cycle_count, 0);
    chk("arst_done", done, 0);
    tick();
    rst = 0;
    go(0);
    chk("zero_pass", pass, 1);
    chk("zero_mc", match_count, 0);
    go(1);
    load(0, 3, 999);
    wb(3, 1234);
    chk("run_write_ignored", pass, 1);
    load(0, 4, 44);
    go(31);
    chk("clamp_busy", busy, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
